// File: rtl/alu_exec_stage.sv
// ALU execute stage. Computes the result for the ALU control code and
// holds it in a two-entry elastic buffer (an output register plus a skid
// register) that uses a valid/ready handshake. It also provides zero and
// illegal-opcode flags and a counter of retired operations.
module alu_exec_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  op_a,
   input  logic [XLEN-1:0]  op_b,
   input  logic [3:0]       alu_control,
   input  logic [4:0]       rd_in,
   input  logic             reg_write_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic             zero,
   output logic             illegal_op,
   output logic [4:0]       rd_out,
   output logic             reg_write_out,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

   typedef struct packed {
      logic [XLEN-1:0] res;
      logic            zero;
      logic            illegal;
      logic [4:0]      rd;
      logic            reg_write;
   } entry_t;

   // The reset entry has result 0, so zero reads 1 out of reset.
   localparam entry_t ENTRY_RST = '{res: '0, zero: 1'b1, illegal: 1'b0, rd: '0, reg_write: 1'b0};

   state_e           state_q, state_d;
   entry_t           out_q, out_d, skid_q, skid_d, new_entry;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, fire;

   // Compute the entry for the incoming operation. An unsupported code
   // yields result 0 and suppresses writeback.
   always_comb begin
      new_entry           = ENTRY_RST;
      new_entry.rd        = rd_in;
      new_entry.illegal   = 1'b0;
      unique case (alu_control)
         4'b0000: new_entry.res = op_a & op_b;
         4'b0001: new_entry.res = op_a | op_b;
         4'b0010: new_entry.res = op_a + op_b;
         4'b0011: new_entry.res = op_a ^ op_b;
         4'b0110: new_entry.res = op_a - op_b;
         default: begin
            new_entry.res     = '0;
            new_entry.illegal = 1'b1;
         end
      endcase
      new_entry.zero      = (new_entry.res == '0);
      new_entry.reg_write = reg_write_in & ~new_entry.illegal;
   end

   assign accept = in_valid & in_ready_q;
   assign fire   = out_valid_q & out_ready;

   // Occupancy FSM. Flush discards both entries and any same-cycle accept,
   // but a same-cycle fire still counts.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, fire};
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (accept) begin
               out_d   = new_entry;
               state_d = ONE;
            end
            ONE: begin
               if (accept && fire) begin
                  out_d = new_entry;
               end else if (accept) begin
                  skid_d  = new_entry;
                  state_d = FULL;
               end else if (fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: if (fire) begin
               out_d   = skid_q;
               state_d = ONE;
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   // State and data registers, with an asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         out_q       <= ENTRY_RST;
         skid_q      <= ENTRY_RST;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign result        = out_q.res;
   assign zero          = out_q.zero;
   assign illegal_op    = out_q.illegal;
   assign rd_out        = out_q.rd;
   assign reg_write_out = out_q.reg_write;
   assign op_count      = cnt_q;

endmodule
